// File: rtl/micro_tile_pkg.sv
// Shared types and constants for the micro-tile stimulus/checker blocks.
package micro_tile_pkg;

    // Checker run-control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam logic [7:0] LFSR_TAPS    = 8'hB8;
    localparam logic [7:0] DEFAULT_KEY  = 8'h42;
    localparam logic [7:0] DEFAULT_SEED = 8'h01;
    localparam logic [7:0] NO_ERR_IDX   = 8'hFF;

    // One step of the 8-bit right-shifting Galois LFSR (maximal length 255).
    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return (l >> 1) ^ (l[0] ? LFSR_TAPS : 8'h00);
    endfunction

endpackage

// File: rtl/micro_lfsr8.sv
// 8-bit Galois LFSR with synchronous load; shared by the micro-tile stimulus blocks.
module micro_lfsr8
    import micro_tile_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic       enable_i,
    input  logic [7:0] seed_i,
    output logic [7:0] state_o
);

    logic [7:0] state_q;
    logic [7:0] state_d;

    // Load wins over advance; otherwise hold.
    always_comb begin
        state_d = state_q;
        if (load_i) begin
            state_d = seed_i;
        end else if (enable_i) begin
            state_d = lfsr_step(state_q);
        end
    end

    // State register; resets to a non-zero value so the LFSR can never lock up at zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= 8'h01;
        end else begin
            state_q <= state_d;
        end
    end

    assign state_o = state_q;

endmodule

// File: rtl/micro_tile_checker.sv
// Drives an LFSR vector stream into a micro tile and checks its outputs against
// vector ^ KEY after LAT cycles, counting mismatches.
// Handshake: start is a single-cycle request accepted only in IDLE or DONE; it is
// ignored in RUN and DRAIN. done is a level held until the next accepted start or rst.
module micro_tile_checker
    import micro_tile_pkg::*;
#(
    parameter logic [7:0] KEY         = DEFAULT_KEY,
    parameter logic [7:0] SEED        = DEFAULT_SEED,
    parameter int         NUM_VECTORS = 255,
    parameter int         LAT         = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    output logic [7:0] dut_ui_in,
    input  logic [7:0] dut_uo_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [7:0] err_count,
    output logic [7:0] first_err_idx,
    output state_e     dbg_state_o
);

    // A zero seed would freeze the LFSR, so it is replaced by 0x01.
    localparam logic [7:0] SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;
    localparam logic [7:0] LAST_IDX   = 8'(NUM_VECTORS - 1);
    localparam logic [2:0] LAST_DRAIN = 3'(LAT - 1);

    state_e     state_q, state_d;
    logic [7:0] vec_idx_q, vec_idx_d;
    logic [7:0] ui_q, ui_d;
    logic [2:0] drain_q, drain_d;
    logic [7:0] err_q, err_d;
    logic [7:0] first_q, first_d;
    logic [7:0] lfsr_vec;
    logic       launch;
    logic       lfsr_en;
    logic       mismatch;

    // Expected-value delay line: stage LAT-1 lines up with the tile output.
    logic       vld_q [LAT];
    logic [7:0] exp_q [LAT];
    logic [7:0] idx_q [LAT];

    assign launch  = start && ((state_q == IDLE) || (state_q == DONE));
    assign lfsr_en = (state_q == RUN) && (vec_idx_q != LAST_IDX);

    // The LFSR holds the vector currently presented on dut_ui_in during RUN.
    micro_lfsr8 u_lfsr (
        .clk      (clk),
        .rst      (rst),
        .load_i   (launch),
        .enable_i (lfsr_en),
        .seed_i   (SEED_EFF),
        .state_o  (lfsr_vec)
    );

    assign mismatch = vld_q[LAT-1] && (dut_uo_out != exp_q[LAT-1]);

    // Run control, vector presentation and mismatch bookkeeping.
    always_comb begin
        state_d   = state_q;
        vec_idx_d = vec_idx_q;
        ui_d      = 8'h00;
        drain_d   = drain_q;
        err_d     = err_q;
        first_d   = first_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d   = RUN;
                    ui_d      = SEED_EFF;
                    vec_idx_d = 8'h00;
                    err_d     = 8'h00;
                    first_d   = NO_ERR_IDX;
                end
            end
            RUN: begin
                if (vec_idx_q == LAST_IDX) begin
                    state_d = DRAIN;
                    drain_d = 3'd0;
                end else begin
                    vec_idx_d = vec_idx_q + 8'd1;
                    ui_d      = lfsr_step(lfsr_vec);
                end
            end
            DRAIN: begin
                if (drain_q == LAST_DRAIN) begin
                    state_d = DONE;
                end else begin
                    drain_d = drain_q + 3'd1;
                end
            end
            default: state_d = IDLE;
        endcase
        // Valid slots only exist in RUN/DRAIN, so this never collides with a launch.
        if (mismatch) begin
            if (err_q != 8'hFF) begin
                err_d = err_q + 8'd1;
            end
            if (first_q == NO_ERR_IDX) begin
                first_d = idx_q[LAT-1];
            end
        end
    end

    // Control and result registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            vec_idx_q <= 8'h00;
            ui_q      <= 8'h00;
            drain_q   <= 3'd0;
            err_q     <= 8'h00;
            first_q   <= NO_ERR_IDX;
        end else begin
            state_q   <= state_d;
            vec_idx_q <= vec_idx_d;
            ui_q      <= ui_d;
            drain_q   <= drain_d;
            err_q     <= err_d;
            first_q   <= first_d;
        end
    end

    // Each RUN cycle pushes the expected response for the vector on dut_ui_in.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < LAT; i++) begin
                vld_q[i] <= 1'b0;
                exp_q[i] <= 8'h00;
                idx_q[i] <= 8'h00;
            end
        end else begin
            vld_q[0] <= (state_q == RUN);
            exp_q[0] <= ui_q ^ KEY;
            idx_q[0] <= vec_idx_q;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                exp_q[i] <= exp_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
        end
    end

    assign dut_ui_in     = ui_q;
    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign pass          = (state_q == DONE) && (err_q == 8'h00);
    assign err_count     = err_q;
    assign first_err_idx = first_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_micro_tile_checker.sv
// Bench for micro_tile_checker: three checker configurations, each driving a
// behavioural tile with selectable fault mode and latency.
module tb_micro_tile_checker;
    import micro_tile_pkg::*;

    localparam int         NI = 3;
    localparam int         N_P    [NI] = '{255, 20, 1};
    localparam int         LAT_P  [NI] = '{1, 2, 3};
    localparam logic [7:0] KEY_P  [NI] = '{8'h42, 8'h42, 8'h5A};
    localparam logic [7:0] SEED_P [NI] = '{8'h01, 8'h37, 8'h00};

    logic clk = 1'b0;
    logic rst;
    logic       start_v [NI];
    logic [7:0] ui [NI];
    logic [7:0] uo [NI];
    logic       bz [NI];
    logic       dn [NI];
    logic       ps [NI];
    logic [7:0] ec [NI];
    logic [7:0] fe [NI];
    state_e     st [NI];

    // Tile behaviour controls: 0 correct, 1 bit3 stuck-at-1, 2 invert, 3 masked faults.
    int         mode_v [NI];
    int         tile_lat_v [NI];
    logic [7:0] mask [256];

    int n_checks = 0;
    int n_errors = 0;
    int cur_run  = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] tile_fn(input int mode, input logic [7:0] key,
                                           input logic [7:0] x);
        case (mode)
            1:       return (x ^ key) | 8'h08;
            2:       return x ^ 8'hBD;
            3:       return x ^ key ^ mask[x];
            default: return x ^ key;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [7:0] pipe [4];
        initial for (int j = 0; j < 4; j++) pipe[j] = 8'h00;
        always @(posedge clk) begin
            pipe[0] <= ui[g];
            for (int j = 1; j < 4; j++) pipe[j] <= pipe[j-1];
        end
        assign uo[g] = tile_fn(mode_v[g], KEY_P[g], pipe[tile_lat_v[g]-1]);

        micro_tile_checker #(
            .KEY(KEY_P[g]), .SEED(SEED_P[g]), .NUM_VECTORS(N_P[g]), .LAT(LAT_P[g])
        ) u_dut (
            .clk           (clk),
            .rst           (rst),
            .start         (start_v[g]),
            .dut_ui_in     (ui[g]),
            .dut_uo_out    (uo[g]),
            .busy          (bz[g]),
            .done          (dn[g]),
            .pass          (ps[g]),
            .err_count     (ec[g]),
            .first_err_idx (fe[g]),
            .dbg_state_o   (st[g])
        );
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL run%0d %s got=%0h exp=%0h", cur_run, tag, got, exp);
        end
    endtask

    // Vector k of a run, straight from the LFSR rule.
    function automatic logic [7:0] vec_at(input int s, input int k);
        logic [7:0] v;
        v = (SEED_P[s] == 8'h00) ? 8'h01 : SEED_P[s];
        for (int i = 0; i < k; i++) v = (v >> 1) ^ (v[0] ? 8'hB8 : 8'h00);
        return v;
    endfunction

    // Reference: what the tile shows when vector k is checked, given the latency skew.
    task automatic model(input int s, output int e, output int f);
        int j;
        logic [7:0] inp;
        e = 0;
        f = 255;
        for (int k = 0; k < N_P[s]; k++) begin
            j   = k + LAT_P[s] - tile_lat_v[s];
            inp = (j >= 0 && j < N_P[s]) ? vec_at(s, j) : 8'h00;
            if (tile_fn(mode_v[s], KEY_P[s], inp) != (vec_at(s, k) ^ KEY_P[s])) begin
                if (e < 255) e++;
                if (f == 255) f = k;
            end
        end
    endtask

    task automatic check_reset(input int s);
        check_eq("rst_ui",    ui[s], 8'h00);
        check_eq("rst_busy",  bz[s], 1'b0);
        check_eq("rst_done",  dn[s], 1'b0);
        check_eq("rst_pass",  ps[s], 1'b0);
        check_eq("rst_err",   ec[s], 8'h00);
        check_eq("rst_first", fe[s], 8'hFF);
        check_eq("rst_state", st[s], IDLE);
    endtask

    // One run on instance s; abort_at >= 0 pulses rst at that vector, pulse_at >= 0
    // pulses a stray start at that vector.
    task automatic run(input int s, input int abort_at, input int pulse_at);
        int e, f, cnt;
        cur_run++;
        model(s, e, f);
        @(negedge clk);
        start_v[s] = 1'b1;
        @(negedge clk);
        start_v[s] = 1'b0;
        for (int k = 0; k < N_P[s]; k++) begin
            if (k == abort_at) begin
                rst = 1'b1;
                #1;
                check_reset(s);
                @(negedge clk);
                rst = 1'b0;
                repeat (6) @(negedge clk);
                return;
            end
            check_eq("vec", ui[s], vec_at(s, k));
            if (k == 0) begin
                check_eq("busy_run", bz[s], 1'b1);
                check_eq("state_run", st[s], RUN);
                check_eq("err_clr", ec[s], 8'h00);
            end
            start_v[s] = (k == pulse_at);
            @(negedge clk);
        end
        start_v[s] = 1'b0;
        check_eq("ui_drain", ui[s], 8'h00);
        check_eq("busy_drain", bz[s], 1'b1);
        check_eq("done_early", dn[s], 1'b0);
        cnt = 0;
        while (!dn[s] && cnt < 12) begin
            @(negedge clk);
            cnt++;
        end
        check_eq("drain_cycles", cnt, LAT_P[s]);
        check_eq("err_count", ec[s], e);
        check_eq("first_err", fe[s], f);
        check_eq("pass", ps[s], (e == 0));
        check_eq("busy_done", bz[s], 1'b0);
        repeat (3) @(negedge clk);
        check_eq("done_held", dn[s], 1'b1);
        check_eq("err_held", ec[s], e);
        repeat (3) @(negedge clk);
    endtask

    task automatic rand_mask();
        for (int i = 0; i < 256; i++)
            mask[i] = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 256; i++) mask[i] = 8'h00;
        for (int s = 0; s < NI; s++) begin
            start_v[s]    = 1'b0;
            mode_v[s]     = 0;
            tile_lat_v[s] = LAT_P[s];
        end
        repeat (6) @(negedge clk);
        for (int s = 0; s < NI; s++) check_reset(s);
        rst = 1'b0;
        @(negedge clk);

        // Instance 0: default configuration.
        run(0, -1, -1);                                  // clean run
        mode_v[0] = 1; run(0, -1, -1);                   // bit3 stuck high
        mode_v[0] = 0; tile_lat_v[0] = 2; run(0, -1, -1); // tile slower than checker
        tile_lat_v[0] = 1; mode_v[0] = 2; run(0, -1, -1); // inverting tile, saturation
        mode_v[0] = 0; run(0, -1, 100);                  // stray start mid-run
        run(0, 40, -1);                                  // reset mid-run
        for (int s = 0; s < NI; s++) check_reset(s);
        run(0, -1, -1);                                  // clean run after reset

        // Instance 1: LAT=2, short runs with random faults and skews.
        run(1, -1, -1);
        for (int r = 0; r < 6; r++) begin
            mode_v[1]     = $urandom_range(0, 3);
            tile_lat_v[1] = $urandom_range(1, 4);
            rand_mask();
            run(1, -1, -1);
        end

        // Instance 2: single vector, LAT=3, zero seed.
        mode_v[2] = 0; run(2, -1, -1);
        for (int i = 0; i < 256; i++) mask[i] = 8'h00;
        mask[1] = 8'h10;
        mode_v[2] = 3; run(2, -1, -1);                   // mismatch on the final vector
        tile_lat_v[2] = $urandom_range(1, 4); mode_v[2] = 0; run(2, -1, -1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
